// File: rtl/planar_shifter.sv
// Bitplane video shifter: palette/mode registers, word-by-word plane loading, and a pixel
// serialiser. Define BORDER_BLANK_EN to force r/g/b to 0 outside the active picture.
module planar_shifter #(
  parameter int unsigned PLANES     = 4,
  parameter int unsigned COLOR_BITS = 4
) (
  input  logic                  CLOCK_32,
  input  logic                  reset_n,
  input  logic                  de,
  input  logic                  cs,
  input  logic                  rw,
  input  logic [4:0]            addr,
  input  logic                  load,
  input  logic [15:0]           data,
  output logic [15:0]           data_out,
  output logic                  oe,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b
);

  localparam int unsigned NENT = 1 << PLANES;
  localparam int unsigned PW   = 3 * COLOR_BITS;

  logic [PW-1:0] pal_q [NENT];
  logic [1:0]    mode_q;
  logic          cs_q;
  logic          load_q;
  logic [2:0]    wc_q, wc_d;
  logic [1:0]    div_q, div_d;
  logic [15:0]   slot_q  [PLANES];
  logic [15:0]   shreg_q [PLANES];
  logic [PW-1:0] rgb_q, rgb_d;
  logic [15:0]   rd_data;

  logic [2:0]        np_mode, np;
  logic              wr_stb, ld_evt, pal_hit, mode_wr, xfer, tick;
  logic [2:0]        slot_sel;
  logic [PLANES-1:0] idx;
  logic [PW-1:0]     border;

  // Active plane count from mode, clamped to the configured plane count
  always_comb begin
    case (mode_q)
      2'd0:    np_mode = 3'd4;
      2'd1:    np_mode = 3'd2;
      default: np_mode = 3'd1;
    endcase
    np = (np_mode > 3'(PLANES)) ? 3'(PLANES) : np_mode;
  end

  assign wr_stb   = ~cs & cs_q & ~rw;
  assign ld_evt   = ~load & load_q;
  assign pal_hit  = 32'(addr) < NENT;
  assign mode_wr  = wr_stb & (addr == 5'd16);
  assign xfer     = wc_q >= np;
  assign tick     = {1'b0, div_q} == (np - 3'd1);
  // A word arriving in the transfer cycle starts the next group
  assign slot_sel = xfer ? 3'd0 : wc_q;

  always_comb begin
    for (int k = 0; k < int'(PLANES); k++) begin
      idx[k] = shreg_q[k][15] & (k < int'(np));
    end
  end

  always_comb begin
    rd_data = '0;
    if (pal_hit) begin
      rd_data[PW-1:0] = pal_q[addr[PLANES-1:0]];
    end else if (addr == 5'd16) begin
      rd_data[1:0] = mode_q;
    end
  end

`ifdef BORDER_BLANK_EN
  assign border = '0;
`else
  assign border = pal_q[0];
`endif

  assign rgb_d = de ? pal_q[idx] : border;

  always_comb begin
    wc_d = wc_q;
    if (mode_wr) begin
      wc_d = 3'd0;
    end else if (xfer) begin
      wc_d = ld_evt ? 3'd1 : 3'd0;
    end else if (ld_evt) begin
      wc_d = wc_q + 3'd1;
    end
  end

  always_comb begin
    div_d = div_q + 2'd1;
    if (mode_wr || xfer || tick) begin
      div_d = 2'd0;
    end
  end

  // Register file and bus-side edge detectors
  always_ff @(posedge CLOCK_32 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NENT); i++) begin
        pal_q[i] <= '0;
      end
      mode_q   <= 2'd0;
      cs_q     <= 1'b1;
      load_q   <= 1'b1;
      oe       <= 1'b0;
      data_out <= '0;
    end else begin
      cs_q   <= cs;
      load_q <= load;
      oe     <= ~cs & rw;
      data_out <= (~cs & rw) ? rd_data : 16'd0;
      if (wr_stb) begin
        if (pal_hit) begin
          pal_q[addr[PLANES-1:0]] <= data[PW-1:0];
        end else if (addr == 5'd16) begin
          mode_q <= data[1:0];
        end
      end
    end
  end

  // Plane slots, word counter, divider and shift registers
  always_ff @(posedge CLOCK_32 or negedge reset_n) begin
    if (!reset_n) begin
      wc_q  <= 3'd0;
      div_q <= 2'd0;
      for (int k = 0; k < int'(PLANES); k++) begin
        slot_q[k]  <= '0;
        shreg_q[k] <= '0;
      end
    end else begin
      wc_q  <= wc_d;
      div_q <= div_d;
      for (int k = 0; k < int'(PLANES); k++) begin
        if (ld_evt && (int'(slot_sel) == k)) begin
          slot_q[k] <= data;
        end
        if (xfer) begin
          shreg_q[k] <= (k < int'(np)) ? slot_q[k] : 16'd0;
        end else if (tick) begin
          shreg_q[k] <= {shreg_q[k][14:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge CLOCK_32 or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign r = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign g = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign b = rgb_q[COLOR_BITS-1:0];

endmodule
